ce_ls_rs_rx: RTL and testbench
==============================

CE_LS_RS_RX -- requirements
Module: ce_ls_rs_rx

Interface
REQ-001 SHALL have parameter wDataIn, default 18, width of received RS samples (signed).
REQ-002 SHALL have parameter wRef, default 18, width of local ZC reference words (signed, scaled *65536).
REQ-003 SHALL have parameter wDataOut, default 18, width of LS estimate outputs (signed).
REQ-004 clk  in  1  sole clock, all logic on rising edge.
REQ-005 rst  in  1  asynchronous reset, active-high.
REQ-006 sink_valid  in  1  received sample qualifier.
REQ-007 sink_sop  in  1  first sample of RS symbol, valid only with sink_valid.
REQ-008 sink_eop  in  1  last sample of RS symbol, valid only with sink_valid.
REQ-009 sink_real / sink_imag  in  wDataIn each  received RS sample Y.
REQ-010 fftpts_in  in  12  symbol length N, sampled on accepted sop.
REQ-011 ref_addr  out  11  address to external reference ROM (same ROM content as the transmit side).
REQ-012 ref_real / ref_imag  in  wRef each  ROM data X, one clk after ref_addr.
REQ-013 source_valid / source_sop / source_eop  out  1 each  output qualifiers.
REQ-014 source_real / source_imag  out  wDataOut each  LS estimate H.
REQ-015 err  out  1  one-cycle pulse on framing error.

Function
REQ-016 SHALL implement FSM IDLE/RUN; reset state IDLE.
REQ-017 IDLE: sink_valid&sink_sop with 1<=fftpts_in<=2048 -> RUN, latch N, index=0; fftpts_in outside range -> err pulse, stay IDLE, symbol discarded.
REQ-018 IDLE: valid samples without sop SHALL be discarded, no output, no err.
REQ-019 RUN: each sink_valid sample SHALL use index then index+1; sink_valid low holds index (gaps allowed).
REQ-020 ref_addr SHALL equal current sample index combinationally-registered so ROM data aligns with that sample one clk later; input sample delayed one clk internally to match.
REQ-021 H SHALL be Y*conj(X): re=yr*xr+yi*xi, im=yi*xr-yr*xi, full precision (wDataIn+wRef+1 bits), no intermediate truncation.
REQ-022 Result SHALL be rounded half-up (add 2^15) then arithmetic >>16, then saturated to [-2^(wDataOut-1), 2^(wDataOut-1)-1].
REQ-023 Latency sink_valid -> source_valid SHALL be exactly 4 clks, fixed, with sop/eop carried in the same pipeline.
REQ-024 Normal end: sink_eop at index N-1 -> source_eop on that sample, FSM -> IDLE.
REQ-025 sink_eop at index != N-1 -> sample output with source_eop, err pulse, -> IDLE.
REQ-026 index reaches N-1 without eop -> that sample output with source_eop forced, err pulse, -> IDLE.
REQ-027 sink_sop in RUN -> err pulse, current symbol terminated without source_eop, new symbol starts at index 0 with new fftpts_in.
REQ-028 sop and eop on same sample with N=1 SHALL be a valid one-sample symbol.
REQ-029 err SHALL be asserted in the same cycle as the offending sample's output, or 1 clk after sop in IDLE for bad N.

Reset
REQ-030 On rst: FSM IDLE, index 0, ref_addr 0, all pipeline valids 0, source_* 0, err 0, immediately (asynchronous).
REQ-031 Reset mid-symbol SHALL discard in-flight samples; no source_valid for 4 clks after release unless new sop.

Verification
REQ-032 ROM all 65536+0j, N=12, Y=100+50j each -> 12 outputs 100+50j, sop on 1st, eop on 12th, 4 clk latency.
REQ-033 ROM 0+65536j, Y=100+0j -> H=0-100j; Y=-3+0j, X=32768 -> H=-1 (round half-up of -1.5).
REQ-034 Y=131071+131071j, X=46341+46341j -> re saturates 131071, im 0.
REQ-035 N=12, eop on 10th sample -> source_eop on 10th output, err pulse; N=12, no eop -> forced eop on 12th, err.
REQ-036 sink_valid toggled 1/0 during symbol -> ref_addr sequence 0..N-1 unbroken, outputs match gap-free run.
REQ-037 rst asserted at index 5 -> all outputs 0 next cycle; following sop restarts from ref_addr 0.

Source files
------------

// File: rtl/ce_ls_rs_rx.sv
`default_nettype none
// ============================================================================
// Module   : ce_ls_rs_rx
// Purpose  : Least-squares channel estimate over one received reference-signal
//            symbol.  For each accepted sample Y at index k it fetches the
//            local Zadoff-Chu word X[k] (scaled by 65536) from an external
//            ROM and produces H = Y * conj(X) / 65536.  The result is rounded
//            half-up and saturated.  The symbol framing (sop/eop/length) is
//            checked, and any framing fault raises a one-cycle err pulse.
// Ports    : clk, rst                 - clock, asynchronous active-high reset
//            sink_valid/sop/eop       - input sample qualifiers
//            sink_real/sink_imag      - received sample Y
//            fftpts_in                - symbol length N, taken on accepted sop
//            ref_addr                 - reference ROM address (index of sample)
//            ref_real/ref_imag        - ROM data X, one clk after ref_addr
//            source_valid/sop/eop     - output qualifiers (4 clk after input)
//            source_real/source_imag  - LS estimate H
//            err                      - framing error pulse
// Revision : 1.0 - initial release
// ============================================================================
module ce_ls_rs_rx #(
  parameter int wDataIn  = 18,
  parameter int wRef     = 18,
  parameter int wDataOut = 18
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sink_valid,
  input  logic                       sink_sop,
  input  logic                       sink_eop,
  input  logic signed [wDataIn-1:0]  sink_real,
  input  logic signed [wDataIn-1:0]  sink_imag,
  input  logic        [11:0]         fftpts_in,
  output logic        [10:0]         ref_addr,
  input  logic signed [wRef-1:0]     ref_real,
  input  logic signed [wRef-1:0]     ref_imag,
  output logic                       source_valid,
  output logic                       source_sop,
  output logic                       source_eop,
  output logic signed [wDataOut-1:0] source_real,
  output logic signed [wDataOut-1:0] source_imag,
  output logic                       err
);

  // Full-precision product/sum width, plus one guard bit for the rounding add.
  localparam int c_p = wDataIn + wRef + 1;
  localparam int c_w = c_p + 1;

  localparam logic signed [c_w-1:0] c_half = {{(c_w-16){1'b0}}, 1'b1, 15'b0};
  localparam logic signed [c_w-1:0] c_max  = {{(c_w-wDataOut+1){1'b0}}, {(wDataOut-1){1'b1}}};
  localparam logic signed [c_w-1:0] c_min  = {{(c_w-wDataOut+1){1'b1}}, {(wDataOut-1){1'b0}}};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [10:0] r_index, w_index_nxt, w_idx_cur;
  logic [11:0] r_n, w_n_nxt, w_n_cur;
  logic        w_start, w_n_ok, w_last, w_accept, w_eop, w_err, w_bad_n;
  logic        r_err_fast;

  // Stage 1: delayed sample, aligned with the ROM word now on ref_*.
  logic                      r_v1, r_sop1, r_eop1, r_err1;
  logic signed [wDataIn-1:0] r_y1_re, r_y1_im;
  // Stage 2: full-precision complex product.
  logic                      r_v2, r_sop2, r_eop2, r_err2;
  logic signed [c_p-1:0]     r_p2_re, r_p2_im;
  // Stage 3: rounded and saturated estimate.
  logic                       r_v3, r_sop3, r_eop3, r_err3;
  logic signed [wDataOut-1:0] r_h3_re, r_h3_im;
  logic                       r_err_out;

  logic signed [c_p-1:0] w_yr, w_yi, w_xr, w_xi, w_mul_re, w_mul_im;

  // --------------------------------------------------------------------------
  // Framing FSM: next state and per-sample decisions
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_index_nxt = r_index;
    w_n_nxt     = r_n;
    w_accept    = 1'b0;
    w_eop       = 1'b0;
    w_err       = 1'b0;
    w_bad_n     = 1'b0;
    w_start     = sink_valid & sink_sop;
    w_n_ok      = (fftpts_in != 12'd0) && (fftpts_in <= 12'd2048);
    // A sop sample always sits at index 0 with the freshly presented length,
    // even when it interrupts a running symbol.
    w_idx_cur   = w_start ? 11'd0 : r_index;
    w_n_cur     = w_start ? fftpts_in : r_n;
    w_last      = ({1'b0, w_idx_cur} == (w_n_cur - 12'd1));

    if (w_start) begin
      if (w_n_ok) begin
        w_accept = 1'b1;
        w_n_nxt  = fftpts_in;
        w_err    = (r_state == S_RUN);
      end else begin
        w_bad_n     = 1'b1;
        w_state_nxt = S_IDLE;
        w_index_nxt = 11'd0;
      end
    end else if (sink_valid && (r_state == S_RUN)) begin
      w_accept = 1'b1;
    end

    if (w_accept) begin
      // eop is forced on the last index; eop and last-index must coincide.
      w_eop = sink_eop | w_last;
      if (sink_eop != w_last) begin
        w_err = 1'b1;
      end
      if (w_eop) begin
        w_state_nxt = S_IDLE;
        w_index_nxt = 11'd0;
      end else begin
        w_state_nxt = S_RUN;
        w_index_nxt = w_idx_cur + 11'd1;
      end
    end
  end

  // The ROM registers this address, so its data lines up with stage 1.
  assign ref_addr = w_idx_cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_index    <= 11'd0;
      r_n        <= 12'd0;
      r_err_fast <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_index    <= w_index_nxt;
      r_n        <= w_n_nxt;
      r_err_fast <= w_bad_n;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: H = Y * conj(X)
  // --------------------------------------------------------------------------
  assign w_yr = {{(c_p-wDataIn){r_y1_re[wDataIn-1]}}, r_y1_re};
  assign w_yi = {{(c_p-wDataIn){r_y1_im[wDataIn-1]}}, r_y1_im};
  assign w_xr = {{(c_p-wRef){ref_real[wRef-1]}}, ref_real};
  assign w_xi = {{(c_p-wRef){ref_imag[wRef-1]}}, ref_imag};

  // Exact: each product fits wDataIn+wRef bits, the sum one bit more.
  assign w_mul_re = (w_yr * w_xr) + (w_yi * w_xi);
  assign w_mul_im = (w_yi * w_xr) - (w_yr * w_xi);

  function automatic logic signed [wDataOut-1:0] f_round_sat(input logic signed [c_p-1:0] v);
    logic signed [c_w-1:0] r;
    r = $signed({v[c_p-1], v}) + c_half;
    r = r >>> 16;
    if (r > c_max) begin
      r = c_max;
    end else if (r < c_min) begin
      r = c_min;
    end
    return $signed(r[wDataOut-1:0]);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_sop1  <= 1'b0;
      r_eop1  <= 1'b0;
      r_err1  <= 1'b0;
      r_y1_re <= '0;
      r_y1_im <= '0;
      r_v2    <= 1'b0;
      r_sop2  <= 1'b0;
      r_eop2  <= 1'b0;
      r_err2  <= 1'b0;
      r_p2_re <= '0;
      r_p2_im <= '0;
      r_v3    <= 1'b0;
      r_sop3  <= 1'b0;
      r_eop3  <= 1'b0;
      r_err3  <= 1'b0;
      r_h3_re <= '0;
      r_h3_im <= '0;
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_real  <= '0;
      source_imag  <= '0;
      r_err_out    <= 1'b0;
    end else begin
      r_v1   <= w_accept;
      r_sop1 <= w_accept & sink_sop;
      r_eop1 <= w_eop;
      r_err1 <= w_accept & w_err;
      if (w_accept) begin
        r_y1_re <= sink_real;
        r_y1_im <= sink_imag;
      end

      r_v2   <= r_v1;
      r_sop2 <= r_sop1;
      r_eop2 <= r_eop1;
      r_err2 <= r_err1;
      if (r_v1) begin
        r_p2_re <= w_mul_re;
        r_p2_im <= w_mul_im;
      end

      r_v3   <= r_v2;
      r_sop3 <= r_sop2;
      r_eop3 <= r_eop2;
      r_err3 <= r_err2;
      if (r_v2) begin
        r_h3_re <= f_round_sat(r_p2_re);
        r_h3_im <= f_round_sat(r_p2_im);
      end

      source_valid <= r_v3;
      source_sop   <= r_v3 & r_sop3;
      source_eop   <= r_v3 & r_eop3;
      source_real  <= r_v3 ? r_h3_re : '0;
      source_imag  <= r_v3 ? r_h3_im : '0;
      r_err_out    <= r_v3 & r_err3;
    end
  end

  // Sample-attached errors leave with the sample; a rejected length reports
  // one clk after its sop.
  assign err = r_err_out | r_err_fast;

endmodule
`default_nettype wire

// File: tb/tb_ce_ls_rs_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ce_ls_rs_rx
// Purpose  : Self-checking bench for ce_ls_rs_rx.  A registered ROM model
//            feeds ref_*; a sample-level reference model predicts every
//            output cycle, which is compared against the recorded outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ce_ls_rs_rx;

  localparam int MAXC = 8192;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sink_valid = 1'b0, sink_sop = 1'b0, sink_eop = 1'b0;
  logic signed [17:0] sink_real = '0, sink_imag = '0;
  logic [11:0] fftpts_in = '0;
  logic [10:0] ref_addr;
  logic signed [17:0] ref_real = '0, ref_imag = '0;
  logic source_valid, source_sop, source_eop, err;
  logic signed [17:0] source_real, source_imag;

  int cyc = 0, checks = 0, errors = 0, last_k = 0;

  // Packed per-cycle view: [39]=valid [38]=sop [37]=eop [36]=err [35:18]=re [17:0]=im
  logic [39:0] exp_vec [MAXC];
  logic [39:0] obs_vec [MAXC];
  logic signed [17:0] rom_re [2048];
  logic signed [17:0] rom_im [2048];

  // Reference model state: inside a symbol, next index, length.
  bit m_run = 1'b0;
  int m_idx = 0;
  int m_n   = 0;

  ce_ls_rs_rx #(.wDataIn(18), .wRef(18), .wDataOut(18)) dut (
    .clk(clk), .rst(rst),
    .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_real(sink_real), .sink_imag(sink_imag), .fftpts_in(fftpts_in),
    .ref_addr(ref_addr), .ref_real(ref_real), .ref_imag(ref_imag),
    .source_valid(source_valid), .source_sop(source_sop), .source_eop(source_eop),
    .source_real(source_real), .source_imag(source_imag), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    ref_real <= rom_re[ref_addr];
    ref_imag <= rom_im[ref_addr];
  end

  always @(negedge clk) begin
    if (cyc < MAXC)
      obs_vec[cyc] <= source_valid ? {1'b1, source_sop, source_eop, err, source_real, source_imag}
                                   : {1'b0, source_sop, source_eop, err, 36'd0};
  end

  function automatic logic [17:0] f_q(input longint v);
    longint r;
    r = (v + 64'sd32768) >>> 16;
    if (r > 131071) r = 131071;
    else if (r < -131072) r = -131072;
    return r[17:0];
  endfunction

  function automatic logic [35:0] f_ls(input longint yr, input longint yi,
                                       input longint xr, input longint xi);
    return {f_q(yr * xr + yi * xi), f_q(yi * xr - yr * xi)};
  endfunction

  function automatic int rnd18();
    return int'($urandom_range(0, 262143)) - 131072;
  endfunction

  // Drive one cycle of input and record what the spec says must come out.
  task automatic drive(input bit v, input bit s, input bit e, input int n,
                       input int yr, input int yi);
    bit take, er, last, eo;
    @(negedge clk);
    sink_valid = v; sink_sop = s; sink_eop = e; fftpts_in = n[11:0];
    sink_real = yr[17:0]; sink_imag = yi[17:0];
    last_k = cyc;
    take = 1'b0; er = 1'b0;
    if (v) begin
      if (s) begin
        if (n >= 1 && n <= 2048) begin
          er = m_run; m_run = 1'b1; m_n = n; m_idx = 0; take = 1'b1;
        end else begin
          m_run = 1'b0;
          exp_vec[cyc+1][36] = 1'b1;
        end
      end else if (m_run) begin
        take = 1'b1;
      end
    end
    if (take) begin
      last = (m_idx == m_n - 1);
      eo = e | last;
      if (e != last) er = 1'b1;
      exp_vec[cyc+4] = {1'b1, s, eo, er | exp_vec[cyc+4][36],
                        f_ls(yr, yi, rom_re[m_idx], rom_im[m_idx])};
      if (eo) m_run = 1'b0;
      else m_idx++;
    end
  endtask

  task automatic idle(input int k);
    repeat (k) drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({source_valid, source_sop, source_eop, err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0000", {source_valid, source_sop, source_eop, err});
    end
    checks++;
    if (source_real !== 18'd0 || source_imag !== 18'd0) begin
      errors++;
      $display("FAIL reset_data got %h/%h exp 0/0", source_real, source_imag);
    end
    checks++;
    if (ref_addr !== 11'd0) begin
      errors++;
      $display("FAIL reset_ref_addr got %0d exp 0", ref_addr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unity();
    int c0, k0;
    c0 = cyc;
    for (int i = 0; i < 2048; i++) begin rom_re[i] = 18'sd65536; rom_im[i] = 18'sd0; end
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, i == 0, i == 11, 12, 100, 50);
      if (i == 0) k0 = last_k;
    end
    idle(8);
    @(negedge clk);
    checks++;
    if (obs_vec[k0+3][39] !== 1'b0 || obs_vec[k0+4] !== {4'b1100, 18'd100, 18'd50}) begin
      errors++;
      $display("FAIL unity_latency got %h then %h exp valid only at +4", obs_vec[k0+3], obs_vec[k0+4]);
    end
    for (int c = c0; c < cyc; c++) begin
      checks++;
      if (obs_vec[c] !== exp_vec[c]) begin
        errors++;
        $display("FAIL unity cyc=%0d got %h exp %h", c, obs_vec[c], exp_vec[c]);
      end
    end
  endtask

  task automatic test_rotate_round();
    int c0, k0, k4;
    c0 = cyc;
    for (int i = 0; i < 4; i++) begin rom_re[i] = 18'sd0; rom_im[i] = 18'sd65536; end
    rom_re[4] = 18'sd32768; rom_im[4] = 18'sd0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, i == 0, i == 4, 5, (i == 4) ? -3 : 100, 0);
      if (i == 0) k0 = last_k;
      if (i == 4) k4 = last_k;
    end
    idle(8);
    @(negedge clk);
    checks++;
    if (obs_vec[k0+4][35:0] !== {18'h00000, 18'h3FF9C}) begin
      errors++;
      $display("FAIL rotate got %h exp 0/-100", obs_vec[k0+4][35:0]);
    end
    checks++;
    if (obs_vec[k4+4][35:0] !== {18'h3FFFF, 18'h00000}) begin
      errors++;
      $display("FAIL round_half_up got %h exp -1/0", obs_vec[k4+4][35:0]);
    end
    for (int c = c0; c < cyc; c++) begin
      checks++;
      if (obs_vec[c] !== exp_vec[c]) begin
        errors++;
        $display("FAIL rotate_round cyc=%0d got %h exp %h", c, obs_vec[c], exp_vec[c]);
      end
    end
  endtask

  task automatic test_saturation();
    int c0, k0;
    c0 = cyc;
    rom_re[0] = 18'sd46341; rom_im[0] = 18'sd46341;
    rom_re[1] = 18'sd46341; rom_im[1] = 18'sd46341;
    rom_re[2] = 18'sd65536; rom_im[2] = 18'sd0;
    drive(1'b1, 1'b1, 1'b0, 3, 131071, 131071);
    k0 = last_k;
    drive(1'b1, 1'b0, 1'b0, 3, -131072, -131072);
    drive(1'b1, 1'b0, 1'b1, 3, -131072, 0);
    idle(8);
    @(negedge clk);
    checks++;
    if (obs_vec[k0+4][35:0] !== {18'h1FFFF, 18'h00000}) begin
      errors++;
      $display("FAIL sat_pos got %h exp 131071/0", obs_vec[k0+4][35:0]);
    end
    for (int c = c0; c < cyc; c++) begin
      checks++;
      if (obs_vec[c] !== exp_vec[c]) begin
        errors++;
        $display("FAIL saturation cyc=%0d got %h exp %h", c, obs_vec[c], exp_vec[c]);
      end
    end
  endtask

  task automatic test_framing();
    int c0, k_early, k_force, k_bad;
    c0 = cyc;
    for (int i = 0; i < 2048; i++) begin rom_re[i] = rnd18(); rom_im[i] = rnd18(); end
    // eop early on the 10th sample, then stray samples while idle
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, i == 0, i == 9, 12, rnd18(), rnd18());
      if (i == 9) k_early = last_k;
    end
    drive(1'b1, 1'b0, 1'b0, 12, 5, 5);
    drive(1'b1, 1'b0, 1'b1, 12, 6, 6);
    idle(6);
    // no eop: forced on 12th, 13th discarded
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, i == 0, 1'b0, 12, rnd18(), rnd18());
      if (i == 11) k_force = last_k;
    end
    idle(6);
    // sop inside a running symbol
    for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 1'b0, 12, rnd18(), rnd18());
    for (int i = 0; i < 4; i++) drive(1'b1, i == 0, i == 3, 4, rnd18(), rnd18());
    idle(6);
    // out-of-range lengths
    drive(1'b1, 1'b1, 1'b0, 0, 1, 1);
    k_bad = last_k;
    drive(1'b1, 1'b0, 1'b0, 0, 2, 2);
    idle(3);
    drive(1'b1, 1'b1, 1'b0, 2049, 3, 3);
    idle(3);
    drive(1'b1, 1'b1, 1'b1, 4095, 3, 3);
    idle(3);
    // one-sample symbols
    drive(1'b1, 1'b1, 1'b1, 1, rnd18(), rnd18());
    idle(2);
    drive(1'b1, 1'b1, 1'b0, 1, rnd18(), rnd18());
    idle(6);
    // longest symbol
    for (int i = 0; i < 2048; i++) drive(1'b1, i == 0, i == 2047, 2048, rnd18(), rnd18());
    idle(8);
    @(negedge clk);
    checks++;
    if (obs_vec[k_early+4][39:36] !== 4'b1011) begin
      errors++;
      $display("FAIL early_eop got %b exp 1011", obs_vec[k_early+4][39:36]);
    end
    checks++;
    if (obs_vec[k_force+4][39:36] !== 4'b1011) begin
      errors++;
      $display("FAIL forced_eop got %b exp 1011", obs_vec[k_force+4][39:36]);
    end
    checks++;
    if (obs_vec[k_bad+1][39:36] !== 4'b0001) begin
      errors++;
      $display("FAIL bad_n_err got %b exp 0001", obs_vec[k_bad+1][39:36]);
    end
    for (int c = c0; c < cyc; c++) begin
      checks++;
      if (obs_vec[c] !== exp_vec[c]) begin
        errors++;
        $display("FAIL framing cyc=%0d got %h exp %h", c, obs_vec[c], exp_vec[c]);
      end
    end
  endtask

  task automatic test_gaps();
    int c0, sent;
    c0 = cyc;
    sent = 0;
    for (int i = 0; i < 2048; i++) begin rom_re[i] = rnd18(); rom_im[i] = rnd18(); end
    while (sent < 16) begin
      if ($urandom_range(0, 1) == 1) begin
        drive(1'b1, sent == 0, sent == 15, 16, rnd18(), rnd18());
        #1;
        checks++;
        if (ref_addr !== sent[10:0]) begin
          errors++;
          $display("FAIL gap_ref_addr got %0d exp %0d", ref_addr, sent);
        end
        sent++;
      end else begin
        drive(1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 16, rnd18(), rnd18());
        #1;
        if (sent > 0) begin
          checks++;
          if (ref_addr !== sent[10:0]) begin
            errors++;
            $display("FAIL gap_hold_addr got %0d exp %0d", ref_addr, sent);
          end
        end
      end
    end
    idle(8);
    @(negedge clk);
    for (int c = c0; c < cyc; c++) begin
      checks++;
      if (obs_vec[c] !== exp_vec[c]) begin
        errors++;
        $display("FAIL gaps cyc=%0d got %h exp %h", c, obs_vec[c], exp_vec[c]);
      end
    end
  endtask

  task automatic test_random();
    int c0, n, len, mode, k;
    c0 = cyc;
    for (int i = 0; i < 2048; i++) begin rom_re[i] = rnd18(); rom_im[i] = rnd18(); end
    for (int s = 0; s < 30; s++) begin
      mode = $urandom_range(0, 4);
      n = $urandom_range(1, 20);
      k = $urandom_range(0, n - 1);
      case (mode)
        0: len = n;
        1: len = k + 1;
        2: len = n + 1;
        3: len = k + 1;
        default: begin
          len = 3;
          n = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(2049, 4095);
        end
      endcase
      for (int i = 0; i < len; i++) begin
        while ($urandom_range(0, 3) == 0)
          drive(1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, n, rnd18(), rnd18());
        drive(1'b1, i == 0, (mode == 0 && i == n - 1) || (mode == 1 && i == k), n, rnd18(), rnd18());
      end
    end
    idle(10);
    @(negedge clk);
    for (int c = c0; c < cyc; c++) begin
      checks++;
      if (obs_vec[c] !== exp_vec[c]) begin
        errors++;
        $display("FAIL random cyc=%0d got %h exp %h", c, obs_vec[c], exp_vec[c]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int c0;
    c0 = cyc;
    for (int i = 0; i < 2048; i++) begin rom_re[i] = 18'sd65536; rom_im[i] = 18'sd0; end
    for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 1'b0, 12, 200 + i, -7);
    idle(1);
    #2 rst = 1'b1;
    m_run = 1'b0;
    m_idx = 0;
    for (int c = last_k + 1; c < MAXC; c++) exp_vec[c] = '0;
    #1;
    checks++;
    if ({source_valid, source_sop, source_eop, err} !== 4'b0000 ||
        source_real !== 18'd0 || source_imag !== 18'd0) begin
      errors++;
      $display("FAIL midreset_outputs got %b %h %h exp all zero",
               {source_valid, source_sop, source_eop, err}, source_real, source_imag);
    end
    checks++;
    if (ref_addr !== 11'd0) begin
      errors++;
      $display("FAIL midreset_ref_addr got %0d exp 0", ref_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    idle(4);
    drive(1'b1, 1'b1, 1'b0, 3, 11, 22);
    #1;
    checks++;
    if (ref_addr !== 11'd0) begin
      errors++;
      $display("FAIL restart_ref_addr got %0d exp 0", ref_addr);
    end
    drive(1'b1, 1'b0, 1'b0, 3, 33, 44);
    drive(1'b1, 1'b0, 1'b1, 3, 55, 66);
    idle(8);
    @(negedge clk);
    for (int c = c0; c < cyc; c++) begin
      checks++;
      if (obs_vec[c] !== exp_vec[c]) begin
        errors++;
        $display("FAIL reset_mid cyc=%0d got %h exp %h", c, obs_vec[c], exp_vec[c]);
      end
    end
  endtask

  initial begin
    for (int c = 0; c < MAXC; c++) exp_vec[c] = '0;
    for (int i = 0; i < 2048; i++) begin rom_re[i] = '0; rom_im[i] = '0; end
    test_reset();
    test_unity();
    test_rotate_round();
    test_saturation();
    test_framing();
    test_gaps();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
